// File: rtl/shift_sched_ctrl.sv
// Round-robin scheduler that shares one left-shift register between requesters A and B.
// Grants one job at a time, loads the shifter, issues amt shift strobes, returns the tagged result.
module shift_sched_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_data,
    input  logic [AMT_W-1:0] a_amt,
    output logic             a_gnt,
    input  logic             b_req,
    input  logic [WIDTH-1:0] b_data,
    input  logic [AMT_W-1:0] b_amt,
    output logic             b_gnt,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy,
    output logic             sr_load,
    output logic             sr_shift,
    output logic [WIDTH-1:0] sr_din,
    input  logic [WIDTH-1:0] sr_dout
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q;
    logic             id_q;
    logic             last_gnt_q;
    logic [WIDTH-1:0] data_q;
    logic [AMT_W-1:0] amt_q;
    logic [AMT_W-1:0] cnt_q;

    logic             a_gnt_q;
    logic             b_gnt_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic             busy_q;
    logic             sr_load_q;
    logic             sr_shift_q;
    logic [WIDTH-1:0] sr_din_q;

    // Winner id: 0 = A, 1 = B; on a tie the requester opposite the last grant wins.
    logic win_d;

    always_comb begin
        win_d = b_req;
        if (a_req && b_req) begin
            win_d = ~last_gnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            last_gnt_q  <= 1'b1;
            data_q      <= '0;
            amt_q       <= '0;
            cnt_q       <= '0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            busy_q      <= 1'b0;
            sr_load_q   <= 1'b0;
            sr_shift_q  <= 1'b0;
            sr_din_q    <= '0;
        end else begin
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            res_valid_q <= 1'b0;
            sr_load_q   <= 1'b0;
            sr_shift_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        state_q    <= LOAD;
                        id_q       <= win_d;
                        last_gnt_q <= win_d;
                        data_q     <= win_d ? b_data : a_data;
                        amt_q      <= win_d ? b_amt : a_amt;
                        sr_din_q   <= win_d ? b_data : a_data;
                        a_gnt_q    <= ~win_d;
                        b_gnt_q    <= win_d;
                        sr_load_q  <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt_q <= amt_q;
                    if (amt_q != '0) begin
                        state_q    <= SHIFT;
                        sr_shift_q <= 1'b1;
                    end else begin
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        res_data_q  <= data_q;
                        res_id_q    <= id_q;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == AMT_W'(1)) begin
                        // The shifter takes its final shift on this same edge, so the
                        // registered result anticipates it to match sr_dout during DONE.
                        state_q     <= DONE;
                        res_valid_q <= 1'b1;
                        res_data_q  <= sr_dout << 1;
                        res_id_q    <= id_q;
                    end else begin
                        sr_shift_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
    assign sr_load   = sr_load_q;
    assign sr_shift  = sr_shift_q;
    assign sr_din    = sr_din_q;

endmodule

// File: tb/tb_shift_sched_ctrl.sv
// Bench for shift_sched_ctrl: shifter model, vector table, hand sequences, randomized jobs.
module tb_shift_sched_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, b_req;
    logic [3:0] a_data, b_data;
    logic [1:0] a_amt, b_amt;
    logic       a_gnt, b_gnt, res_valid, res_id, busy, sr_load, sr_shift;
    logic [3:0] res_data, sr_din, sr_dout;

    logic [3:0] sh_reg = 4'b0;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic       last_gnt_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shifter datapath model.
    always @(posedge clk) begin
        if (sr_load) sh_reg <= sr_din;
        else if (sr_shift) sh_reg <= {sh_reg[2:0], 1'b0};
    end
    assign sr_dout = sh_reg;

    shift_sched_ctrl #(.WIDTH(4), .AMT_W(2)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_data(a_data), .a_amt(a_amt), .a_gnt(a_gnt),
        .b_req(b_req), .b_data(b_data), .b_amt(b_amt), .b_gnt(b_gnt),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .busy(busy),
        .sr_load(sr_load), .sr_shift(sr_shift), .sr_din(sr_din), .sr_dout(sr_dout)
    );

    typedef struct {
        logic       ar;
        logic [3:0] ad;
        logic [1:0] aa;
        logic       br;
        logic [3:0] bd;
        logic [1:0] ba;
        logic       eid;
        logic [3:0] eres;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'({a_gnt, b_gnt}), 32'd0);
        check({tag, "_res"}, 32'({res_valid, res_id, res_data}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sr"}, 32'({sr_load, sr_shift, sr_din}), 32'd0);
    endtask

    // Issue one job from IDLE (called at a negedge) and follow it cycle by cycle.
    task automatic do_job(input logic ar, input logic [3:0] ad, input logic [1:0] aa,
                          input logic br, input logic [3:0] bd, input logic [1:0] ba,
                          input logic eid, input logic [3:0] eres);
        logic [3:0] d;
        int         n;
        d = eid ? bd : ad;
        n = int'(eid ? ba : aa);
        a_req = ar; a_data = ad; a_amt = aa;
        b_req = br; b_data = bd; b_amt = ba;
        @(negedge clk);
        check("a_gnt", 32'(a_gnt), 32'(!eid));
        check("b_gnt", 32'(b_gnt), 32'(eid));
        check("load", 32'({sr_load, sr_shift, busy}), 32'b101);
        check("sr_din", 32'(sr_din), 32'(d));
        a_req = 1'b0; b_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("shift", 32'({sr_shift, sr_load, a_gnt, b_gnt, res_valid}), 32'b10000);
        end
        @(negedge clk);
        check("done_ctl", 32'({res_valid, sr_shift, sr_load, busy}), 32'b1001);
        check("res_data", 32'(res_data), 32'(eres));
        check("res_id", 32'(res_id), 32'(eid));
        @(negedge clk);
        check("idle", 32'({res_valid, busy}), 32'd0);
        last_gnt_m = eid;
    endtask

    initial begin
        logic       seen;
        int         waited;
        int         prev_cyc;
        logic       exp_id;
        logic       ar, br;
        logic [3:0] ad, bd, d;
        logic [1:0] aa, ba, n;

        tbl[0] = '{1'b1, 4'b0100, 2'd1, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b1000};
        tbl[1] = '{1'b0, 4'b0000, 2'd0, 1'b1, 4'b0010, 2'd0, 1'b1, 4'b0010};
        tbl[2] = '{1'b1, 4'b1011, 2'd2, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b1100};
        tbl[3] = '{1'b0, 4'b0000, 2'd0, 1'b1, 4'b1111, 2'd3, 1'b1, 4'b1000};
        tbl[4] = '{1'b1, 4'b0110, 2'd1, 1'b1, 4'b0101, 2'd2, 1'b0, 4'b1100};
        tbl[5] = '{1'b1, 4'b1001, 2'd3, 1'b1, 4'b0111, 2'd1, 1'b1, 4'b1110};
        tbl[6] = '{1'b1, 4'b0000, 2'd3, 1'b0, 4'b1010, 2'd2, 1'b0, 4'b0000};
        tbl[7] = '{1'b0, 4'b0101, 2'd2, 1'b1, 4'b1000, 2'd1, 1'b1, 4'b0000};

        rst = 1'b1;
        a_req = 1'b0; a_data = '0; a_amt = '0;
        b_req = 1'b0; b_data = '0; b_amt = '0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        last_gnt_m = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");

        // Reset during the second SHIFT cycle aborts the job silently.
        a_req = 1'b1; a_data = 4'b0001; a_amt = 2'd3;
        @(negedge clk);
        check("abort_gnt", 32'(a_gnt), 32'd1);
        a_req = 1'b0;
        @(negedge clk);
        check("abort_sh1", 32'(sr_shift), 32'd1);
        @(negedge clk);
        check("abort_sh2", 32'(sr_shift), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        last_gnt_m = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1'b1;
        end
        check("abort_quiet", 32'(seen), 32'd0);
        do_job(1'b1, 4'b0011, 2'd0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0011);

        foreach (tbl[i])
            do_job(tbl[i].ar, tbl[i].ad, tbl[i].aa, tbl[i].br, tbl[i].bd, tbl[i].ba,
                   tbl[i].eid, tbl[i].eres);

        // Both requesters held high: grants alternate A,B,A,B spaced amt+3 cycles.
        a_req = 1'b1; a_data = 4'b0011; a_amt = 2'd3;
        b_req = 1'b1; b_data = 4'b0011; b_amt = 2'd3;
        prev_cyc = 0;
        for (int j = 0; j < 4; j++) begin
            exp_id = ~last_gnt_m;
            waited = 0;
            while (!(a_gnt || b_gnt) && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            check("alt_gnt_seen", 32'(a_gnt || b_gnt), 32'd1);
            check("alt_gnt_id", 32'({a_gnt, b_gnt}), exp_id ? 32'b01 : 32'b10);
            if (j > 0) check("alt_spacing", 32'(cyc - prev_cyc), 32'd6);
            prev_cyc = cyc;
            if (j == 3) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            waited = 0;
            while (!res_valid && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            check("alt_res_valid", 32'(res_valid), 32'd1);
            check("alt_res_data", 32'(res_data), 32'b1000);
            check("alt_res_id", 32'(res_id), 32'(exp_id));
            last_gnt_m = exp_id;
        end
        @(negedge clk);
        check("alt_idle", 32'({busy, res_valid}), 32'd0);

        // Randomized jobs against the arithmetic reference.
        for (int k = 0; k < 24; k++) begin
            ar = 1'($urandom_range(0, 1));
            br = 1'($urandom_range(0, 1));
            if (!ar && !br) ar = 1'b1;
            ad = 4'($urandom); bd = 4'($urandom);
            aa = 2'($urandom); ba = 2'($urandom);
            exp_id = (ar && br) ? ~last_gnt_m : br;
            d = exp_id ? bd : ad;
            n = exp_id ? ba : aa;
            do_job(ar, ad, aa, br, bd, ba, exp_id, 4'((int'(d) << int'(n)) % 16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
